alu_issue_ctrl: RTL

Sequencer that owns the driving side of the 2-bit-select, 8-bit-operand, 9-bit-result combinational ALU. It accepts register-to-register or register-to-immediate commands over a valid/ready handshake, reads operands from a 4 x 8-bit register file, and drives alu_sel/in_a/in_b. It then captures the 9-bit result, writes back, and returns result and flags over a second valid/ready handshake. It sits between the CPU decode stage and the ALU.

---
 rtl/alu_issue_ctrl_if.sv | 57 +++++
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between the CPU decode stage, the issue sequencer and the ALU.
//   cmd_*       : command handshake (decode -> sequencer)
//   ld_*        : direct register load strobe (decode -> sequencer)
//   alu_sel/a/b : operands to the combinational ALU (sequencer -> ALU)
//   alu_result  : 9-bit ALU output (ALU -> sequencer)
//   rsp_*       : response handshake (sequencer -> decode)
// Modport slave is the sequencer's view; master is the environment's view.
interface alu_issue_ctrl_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned RES_W  = 9;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [IDX_W-1:0]  cmd_dst;
  logic [IDX_W-1:0]  cmd_src_a;
  logic [IDX_W-1:0]  cmd_src_b;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;

  logic              ld_en;
  logic [IDX_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic [OP_W-1:0]   alu_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [RES_W-1:0]  alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
    input  ld_en, ld_addr, ld_data,
    input  alu_result,
    input  rsp_ready,
    output cmd_ready,
    output alu_sel, alu_a, alu_b,
    output rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
    output ld_en, ld_addr, ld_data,
    output alu_result,
    output rsp_ready,
    input  cmd_ready,
    input  alu_sel, alu_a, alu_b,
    input  rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for a 2-bit-select, 8-bit-operand, 9-bit-result ALU.
// Accepts reg-reg / reg-imm commands, reads operands from a 4 x 8-bit
// register file, drives the ALU for one cycle, writes the result back and
// returns data/carry/zero over a response handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_issue_ctrl_if.slave (command, load, ALU and response signals)
// cmd_ready is the only combinational output (depends on rsp_ready in RESP).
module alu_issue_ctrl (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_N  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic cmd_ready_c;
  logic accept_c;
  logic wb_en_c;
  logic rsp_done_c;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [IDX_W-1:0]  dst_q;

  logic [OP_W-1:0]   alu_sel_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [DATA_W-1:0] opnd_a_c;
  logic [DATA_W-1:0] opnd_b_c;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_carry_q;
  logic              rsp_zero_q;

  logic [DATA_W-1:0] wb_data_c;

  // Operand selection reads pre-edge register contents; loads are not forwarded.
  assign opnd_a_c  = regs_q[bus.cmd_src_a];
  assign opnd_b_c  = bus.cmd_use_imm ? bus.cmd_imm : regs_q[bus.cmd_src_b];
  assign wb_data_c = bus.alu_result[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    accept_c    = 1'b0;
    wb_en_c     = 1'b0;
    rsp_done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          accept_c = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wb_en_c = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // A new command may be accepted on the same edge the response retires.
        cmd_ready_c = bus.rsp_ready;
        if (bus.rsp_ready) begin
          rsp_done_c = 1'b1;
          if (bus.cmd_valid) begin
            accept_c = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ALU operand latches; held outside acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      dst_q     <= '0;
    end else if (accept_c) begin
      alu_sel_q <= bus.cmd_op;
      alu_a_q   <= opnd_a_c;
      alu_b_q   <= opnd_b_c;
      dst_q     <= bus.cmd_dst;
    end
  end

  // Register file: writeback takes priority over a same-index direct load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        if (wb_en_c && (dst_q == IDX_W'(i))) begin
          regs_q[i] <= wb_data_c;
        end else if (bus.ld_en && (bus.ld_addr == IDX_W'(i))) begin
          regs_q[i] <= bus.ld_data;
        end
      end
    end
  end

  // Response registers: captured at the end of ISSUE, held until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else if (wb_en_c) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= wb_data_c;
      rsp_carry_q <= bus.alu_result[DATA_W];
      rsp_zero_q  <= (wb_data_c == '0);
    end else if (rsp_done_c) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule
